poly_voice_osc: RTL
===================

Name: poly_voice_osc

Overview:
Parametrised successor to the single-voice oscillator behind TopLevel. It provides NUM_VOICES independent phase-accumulator voices. Each voice has its own Incr/Gate/WaveType/PulseWidth registers on the existing 8-bit memory-mapped bus, plus readback. The voices are mixed into one averaged Waveform that feeds the DAC path.

Parameters:
NUM_VOICES, 4, voice count; power of two, 1..16
ACC_WIDTH, 16, phase accumulator width; >= OUT_WIDTH+1
OUT_WIDTH, 8, per-voice and mixed output width; >= 8
BASE_ADDR, 16'h0010, bus address of voice 0 register 0

Ports:
Clock  input  1  system clock; all state on rising edge
Reset  input  1  synchronous, active-high reset
BusAddress  input  16  bus address
BusData  inout  8  bus data; driven only during a decoded read
BusReadWrite  input  1  1 = write, 0 = read
BusClock  input  1  bus write strobe; sampled in the Clock domain
Waveform  output  OUT_WIDTH  registered mixed output
VoiceActive  output  NUM_VOICES  per-voice registered gate state

Behaviour:
- Register map: voice v, offset r, at BASE_ADDR + 4*v + r.
  - r=0 Incr[7:0]
  - r=1 Gate[0]
  - r=2 WaveType[1:0]: 0 saw, 1 square, 2 triangle, 3 noise
  - r=3 PulseWidth[7:0]
  - Addresses outside BASE_ADDR .. BASE_ADDR+4*NUM_VOICES-1 are ignored.
- BusClock handling:
  - Double-flop synchronised into Clock, then rising-edge detected.
  - Write: on the detected edge with BusReadWrite=1, BusData is latched into the decoded register. The write is visible 3 Clock cycles after BusClock rises.
  - BusAddress and BusData must be stable while BusClock is high.
- Read: when BusReadWrite=0 and the address decodes, BusData combinationally drives the register value zero-extended to 8 bits. Otherwise BusData is Z.
- Phase:
  - Gate=1: phase <= phase + Incr (zero-extended), modulo 2^ACC_WIDTH.
  - Gate=0: phase <= 0.
  - Incr=0 holds the phase constant.
  - A wrap is the cycle where the add carries out.
- Voice output (registered, 1 cycle after phase; P = phase[ACC_WIDTH-1 -: OUT_WIDTH]):
  - saw = P
  - square = all-ones if phase[ACC_WIDTH-1 -: 8] < PulseWidth, else 0. PulseWidth=0 gives constant 0.
  - triangle = phase[ACC_WIDTH-2 -: OUT_WIDTH] XOR {OUT_WIDTH{phase[ACC_WIDTH-1]}}
  - noise = top OUT_WIDTH bits of a per-voice 16-bit Fibonacci LFSR with taps 16,14,13,11. The LFSR advances one step on each wrap. Its seed is 16'hACE1 XOR v, and it is never all-zero.
  - Gate=0 forces the voice output to 0.
- Mix: sum of all voice outputs at OUT_WIDTH+log2(NUM_VOICES) bits, no overflow. Waveform <= sum >> log2(NUM_VOICES) (truncating), registered.
- Latency: phase -> Waveform is 2 cycles.
- VoiceActive[v] is the registered Gate[v].
- WaveType change: takes effect on the next voice-output register. Phase is not reset; the LFSR state is kept.
- Incr or PulseWidth write while running: used from the next phase update. No glitch reset.
- Reset (at any time, including mid-write):
  - All registers, phases, voice outputs, Waveform and VoiceActive go to 0.
  - LFSRs return to their seeds.
  - The synchroniser and edge detector clear, so a BusClock high held across reset release does not produce a write.

Test Plan:
1. Reset high 10 cycles, then low -> Waveform=0, VoiceActive=0, BusData=Z for all BusReadWrite=1 cycles with no strobe.
2. Write voice0 Incr=0x40, WaveType=0, Gate=1 (0x10, 0x12, 0x11); NUM_VOICES=4 -> phase steps 0x40 per cycle, period 1024 cycles. Waveform ramps 0x00 -> 0x3F (saw/4), rising 1 LSB every 16 cycles, then wraps to 0.
3. Voice0 WaveType=1, PulseWidth=0x80, Incr=0x40 -> Waveform 0x3F for 512 cycles, then 0x00 for 512. With PulseWidth=0x00 -> Waveform constant 0. With PulseWidth=0xFF -> Waveform 0x00 for 4 cycles per period.
4. Voices 0-3 all square, Incr=0x40, PulseWidth=0x80, gated together -> Waveform reaches 0xFF with no overflow. Close voice2 gate (address 0x19=0) -> Waveform 0xBF when high, and VoiceActive=4'b1011.
5. Readback: write 0x5A to 0x14, 0x03 to 0x1E; read both with BusReadWrite=0 -> BusData 0x5A and 0x03. Read 0x20 (out of range) -> BusData=Z; a write to 0x20 changes nothing.
6. Assert Reset for 1 cycle mid-saw with BusClock held high across release -> all registers 0, Waveform 0 within 1 cycle, and no spurious write after release. Noise voice after re-init reproduces the same sequence from seed 0xACE1.

Source files
------------

// File: rtl/poly_voice_osc.sv
// Multi-voice phase-accumulator oscillator with per-voice bus registers and an averaging mixer.
// Bus writes are strobed by BusClock, which is resynchronised into the Clock domain.
module poly_voice_osc #(
    parameter int          NUM_VOICES = 4,
    parameter int          ACC_WIDTH  = 16,
    parameter int          OUT_WIDTH  = 8,
    parameter logic [15:0] BASE_ADDR  = 16'h0010
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           BusAddress,
    inout  wire  [7:0]            BusData,
    input  logic                  BusReadWrite,
    input  logic                  BusClock,
    output logic [OUT_WIDTH-1:0]  Waveform,
    output logic [NUM_VOICES-1:0] VoiceActive
);
    localparam int MIX_SHIFT = $clog2(NUM_VOICES);
    localparam int SUM_WIDTH = OUT_WIDTH + MIX_SHIFT;
    localparam int SEL_WIDTH = (MIX_SHIFT > 0) ? MIX_SHIFT : 1;
    localparam int SUM_ACC   = ACC_WIDTH + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic                  bclk_meta_r, bclk_sync_r, bclk_prev_r;
    logic                  bclk_edge_s, wr_s, in_range_s;
    logic [15:0]           offset_s;
    logic [SEL_WIDTH-1:0]  sel_s;
    logic [7:0]            rd_data_s;
    logic [7:0]            incr_r [NUM_VOICES];
    logic [1:0]            wave_r [NUM_VOICES];
    logic [7:0]            pw_r   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_r;
    logic [OUT_WIDTH-1:0]  voice_out_s [NUM_VOICES];
    logic [SUM_WIDTH-1:0]  sum_s;

    // Strobe synchroniser; reset parks it high so a strobe held across release is not an edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bclk_meta_r <= 1'b1;
            bclk_sync_r <= 1'b1;
            bclk_prev_r <= 1'b1;
        end else begin
            bclk_meta_r <= BusClock;
            bclk_sync_r <= bclk_meta_r;
            bclk_prev_r <= bclk_sync_r;
        end
    end

    assign bclk_edge_s = bclk_sync_r & ~bclk_prev_r;
    assign offset_s    = BusAddress - BASE_ADDR;
    assign in_range_s  = (BusAddress >= BASE_ADDR) && (offset_s < 16'(4 * NUM_VOICES));
    assign sel_s       = offset_s[2 +: SEL_WIDTH];
    assign wr_s        = bclk_edge_s & BusReadWrite & in_range_s;

    // Register file writes from the decoded bus strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            gate_r <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                incr_r[v] <= 8'h00;
                wave_r[v] <= 2'd0;
                pw_r[v]   <= 8'h00;
            end
        end else if (wr_s) begin
            case (offset_s[1:0])
                2'd0:    incr_r[sel_s] <= BusData;
                2'd1:    gate_r[sel_s] <= BusData[0];
                2'd2:    wave_r[sel_s] <= BusData[1:0];
                2'd3:    pw_r[sel_s]   <= BusData;
                default: gate_r        <= gate_r;
            endcase
        end
    end

    // Readback mux, zero-extended to the bus width.
    always_comb begin
        rd_data_s = 8'h00;
        case (offset_s[1:0])
            2'd0:    rd_data_s = incr_r[sel_s];
            2'd1:    rd_data_s = {7'd0, gate_r[sel_s]};
            2'd2:    rd_data_s = {6'd0, wave_r[sel_s]};
            2'd3:    rd_data_s = pw_r[sel_s];
            default: rd_data_s = 8'h00;
        endcase
    end

    assign BusData = (!BusReadWrite && in_range_s) ? rd_data_s : 8'bzzzz_zzzz;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [ACC_WIDTH-1:0] phase_r;
        logic [SUM_ACC-1:0]   phase_sum_s;
        logic [15:0]          lfsr_r;
        logic [OUT_WIDTH-1:0] wave_s, voice_out_r;

        assign phase_sum_s = {1'b0, phase_r} + SUM_ACC'(incr_r[v]);

        // Phase accumulator; the LFSR steps on the carry out of the add.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                phase_r <= '0;
                lfsr_r  <= 16'hACE1 ^ 16'(v);
            end else if (gate_r[v]) begin
                phase_r <= phase_sum_s[ACC_WIDTH-1:0];
                if (phase_sum_s[ACC_WIDTH]) begin
                    lfsr_r <= lfsr_step(lfsr_r);
                end
            end else begin
                phase_r <= '0;
            end
        end

        // Waveform shaping from the current phase.
        always_comb begin
            wave_s = '0;
            case (wave_r[v])
                2'd0:    wave_s = phase_r[ACC_WIDTH-1 -: OUT_WIDTH];
                2'd1:    wave_s = (phase_r[ACC_WIDTH-1 -: 8] < pw_r[v]) ? {OUT_WIDTH{1'b1}}
                                                                         : {OUT_WIDTH{1'b0}};
                2'd2:    wave_s = phase_r[ACC_WIDTH-2 -: OUT_WIDTH]
                                  ^ {OUT_WIDTH{phase_r[ACC_WIDTH-1]}};
                2'd3:    wave_s = lfsr_r[15 -: OUT_WIDTH];
                default: wave_s = '0;
            endcase
            if (!gate_r[v]) begin
                wave_s = '0;
            end else begin
                wave_s = wave_s;
            end
        end

        // Per-voice output register.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                voice_out_r <= '0;
            end else begin
                voice_out_r <= wave_s;
            end
        end

        assign voice_out_s[v] = voice_out_r;
    end

    // Mixer sum, wide enough that all voices at full scale cannot overflow.
    always_comb begin
        sum_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum_s = sum_s + SUM_WIDTH'(voice_out_s[v]);
        end
    end

    // Averaged mix and gate status outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Waveform    <= '0;
            VoiceActive <= '0;
        end else begin
            Waveform    <= OUT_WIDTH'(sum_s >> MIX_SHIFT);
            VoiceActive <= gate_r;
        end
    end

endmodule
